// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-2 stream demultiplexer.
// Depth is fixed at two entries per output port.
package demux_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = occ_t'(0);
  localparam occ_t OCC_FULL  = occ_t'(FIFO_DEPTH);

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with a pop counter. A pushed word is visible on the output one cycle later.
// A push is accepted only when the FIFO is not full; a pop in the same cycle does not free space.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_vld_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_rdy_i,
  output logic              pop_vld_o,
  output logic [DATA_W-1:0] pop_dat_o,
  output occ_t              occ_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  occ_t              occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push;
  logic              pop;

  always_comb begin
    push   = push_vld_i && (occ_q != OCC_FULL);
    pop    = pop_rdy_i && (occ_q != OCC_EMPTY);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = push_dat_i;
      wptr_d        = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (push && !pop) begin
      occ_d = occ_q + occ_t'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - occ_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= OCC_EMPTY;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pop_vld_o = (occ_q != OCC_EMPTY);
  assign pop_dat_o = mem_q[rptr_q];
  assign occ_o     = occ_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/demux_1to2_reg.sv
// Routes one word per cycle by select_i into one of two 2-entry FIFOs; one-cycle latency to either port.
// ready_o depends only on select_i and the selected port's registered occupancy, so a stalled port never blocks the other.
module demux_1to2_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              select_i,
  output logic              valid0_o,
  output logic              valid1_o,
  input  logic              ready0_i,
  input  logic              ready1_i,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [CNT_W-1:0]  cnt0_o,
  output logic [CNT_W-1:0]  cnt1_o
);

  occ_t occ0;
  occ_t occ1;
  logic push0_vld;
  logic push1_vld;

  always_comb begin
    ready_o   = ((select_i ? occ1 : occ0) != OCC_FULL);
    push0_vld = valid_i && ready_o && !select_i;
    push1_vld = valid_i && ready_o && select_i;
  end

  demux_fifo2 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_vld_i (push0_vld),
    .push_dat_i (data_i),
    .pop_rdy_i  (ready0_i),
    .pop_vld_o  (valid0_o),
    .pop_dat_o  (data0_o),
    .occ_o      (occ0),
    .cnt_o      (cnt0_o)
  );

  demux_fifo2 #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_vld_i (push1_vld),
    .push_dat_i (data_i),
    .pop_rdy_i  (ready1_i),
    .pop_vld_o  (valid1_o),
    .pop_dat_o  (data1_o),
    .occ_o      (occ1),
    .cnt_o      (cnt1_o)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_demux_1to2_reg;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          select_i;
  logic          valid0_o, valid1_o;
  logic          ready0_i, ready1_i;
  logic [DW-1:0] data0_o, data1_o;
  logic [CW-1:0] cnt0_o, cnt1_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [CW-1:0] mcnt0 = '0;
  logic [CW-1:0] mcnt1 = '0;

  demux_1to2_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .select_i (select_i),
    .valid0_o (valid0_o),
    .valid1_o (valid1_o),
    .ready0_i (ready0_i),
    .ready1_i (ready1_i),
    .data0_o  (data0_o),
    .data1_o  (data1_o),
    .cnt0_o   (cnt0_o),
    .cnt1_o   (cnt1_o)
  );

  always #5 clk = ~clk;

  // Reference: an input is accepted whenever the chosen port holds fewer than two words.
  function automatic bit m_ready();
    return (select_i ? q1.size() : q0.size()) != 2;
  endfunction

  task automatic drive(input bit v, input bit s, input logic [DW-1:0] d, input bit r0, input bit r1);
    @(negedge clk);
    valid_i = v; select_i = s; data_i = d; ready0_i = r0; ready1_i = r1;
    #1;
  endtask

  task automatic tick();
    bit acc, p0, p1;
    acc = valid_i && m_ready();
    p0  = (q0.size() != 0) && ready0_i;
    p1  = (q1.size() != 0) && ready1_i;
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); mcnt0 = mcnt0 + CW'(1); end
    if (p1) begin void'(q1.pop_front()); mcnt1 = mcnt1 + CW'(1); end
    if (acc) begin
      if (select_i) q1.push_back(data_i);
      else          q0.push_back(data_i);
    end
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete(); mcnt0 = '0; mcnt1 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    valid_i = 0; select_i = 0; data_i = '0; ready0_i = 0; ready1_i = 0;
    rst_n = 0;
    #2;
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(0, 0, '0, 0, 0);
    checks++; if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b expected 00", valid0_o, valid1_o); end
    checks++; if (data0_o !== '0 || data1_o !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0/0", data0_o, data1_o); end
    checks++; if (cnt0_o !== '0 || cnt1_o !== '0) begin errors++; $display("FAIL reset_cnt: got %h/%h expected 0/0", cnt0_o, cnt1_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_sel0: got %b expected 1", ready_o); end
    drive(0, 1, '0, 0, 0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_sel1: got %b expected 1", ready_o); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 0, 32'hA0 + i, 1, 0);
      if (i < 4) begin
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, ready_o); end
      end
      if (i > 0) begin
        checks++; if (valid0_o !== 1'b1 || data0_o !== 32'hA0 + i - 1) begin errors++; $display("FAIL stream_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, valid0_o, data0_o, 32'hA0 + i - 1); end
      end
      checks++; if (valid1_o !== 1'b0) begin errors++; $display("FAIL stream_valid1[%0d]: got %b expected 0", i, valid1_o); end
      tick();
    end
    drive(0, 0, '0, 1, 0);
    checks++; if (cnt0_o !== 16'd4 || valid0_o !== 1'b0) begin errors++; $display("FAIL stream_cnt0: got cnt=%0d v=%b expected cnt=4 v=0", cnt0_o, valid0_o); end
  endtask

  task automatic test_stall();
    drive(1, 1, 32'hB0, 1, 0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stall_acc_b0: got %b expected 1", ready_o); end
    tick();
    drive(1, 1, 32'hB1, 1, 0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stall_acc_b1: got %b expected 1", ready_o); end
    tick();
    drive(1, 1, 32'hB2, 1, 0);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_block_b2: got %b expected 0", ready_o); end
    tick();
    drive(1, 0, 32'hC0, 1, 0);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stall_acc_c0: got %b expected 1", ready_o); end
    tick();
    drive(0, 0, '0, 1, 0);
    checks++; if (valid0_o !== 1'b1 || data0_o !== 32'hC0) begin errors++; $display("FAIL stall_port0_c0: got v=%b d=%h expected v=1 d=c0", valid0_o, data0_o); end
    checks++; if (valid1_o !== 1'b1 || data1_o !== 32'hB0) begin errors++; $display("FAIL stall_port1_head: got v=%b d=%h expected v=1 d=b0", valid1_o, data1_o); end
    tick();
    drive(1, 1, 32'hB2, 1, 1);
    checks++; if (ready_o !== 1'b0 || data1_o !== 32'hB0) begin errors++; $display("FAIL stall_full_pop: got rdy=%b d=%h expected rdy=0 d=b0", ready_o, data1_o); end
    tick();
    drive(1, 1, 32'hB2, 1, 1);
    checks++; if (ready_o !== 1'b1 || data1_o !== 32'hB1) begin errors++; $display("FAIL stall_drain_b1: got rdy=%b d=%h expected rdy=1 d=b1", ready_o, data1_o); end
    tick();
    drive(0, 0, '0, 1, 1);
    checks++; if (valid1_o !== 1'b1 || data1_o !== 32'hB2) begin errors++; $display("FAIL stall_drain_b2: got v=%b d=%h expected v=1 d=b2", valid1_o, data1_o); end
    tick();
    drive(0, 0, '0, 1, 1);
    checks++; if (valid1_o !== 1'b0 || valid0_o !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b%b expected 00", valid0_o, valid1_o); end
  endtask

  task automatic test_push_pop();
    drive(1, 0, 32'h11, 0, 0);
    tick();
    drive(1, 0, 32'h22, 1, 0);
    checks++; if (ready_o !== 1'b1 || valid0_o !== 1'b1 || data0_o !== 32'h11) begin errors++; $display("FAIL pushpop_head: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=11", ready_o, valid0_o, data0_o); end
    tick();
    drive(0, 0, '0, 1, 0);
    checks++; if (valid0_o !== 1'b1 || data0_o !== 32'h22) begin errors++; $display("FAIL pushpop_next: got v=%b d=%h expected v=1 d=22", valid0_o, data0_o); end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++; if (valid0_o !== 1'b0) begin errors++; $display("FAIL pushpop_occ1: got v=%b expected 0 (occupancy was 1)", valid0_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      checks++; if (ready_o !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, ready_o, m_ready()); end
      checks++; if (valid0_o !== (q0.size() != 0) || valid1_o !== (q1.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b%b expected %b%b", i, valid0_o, valid1_o, q0.size() != 0, q1.size() != 0); end
      if (q0.size() != 0) begin
        checks++; if (data0_o !== q0[0]) begin errors++; $display("FAIL rand_data0[%0d]: got %h expected %h", i, data0_o, q0[0]); end
      end
      if (q1.size() != 0) begin
        checks++; if (data1_o !== q1[0]) begin errors++; $display("FAIL rand_data1[%0d]: got %h expected %h", i, data1_o, q1[0]); end
      end
      checks++; if (cnt0_o !== mcnt0 || cnt1_o !== mcnt1) begin errors++; $display("FAIL rand_cnt[%0d]: got %h/%h expected %h/%h", i, cnt0_o, cnt1_o, mcnt0, mcnt1); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, i >= 2, 32'hD0 + i, 0, 0);
      tick();
    end
    drive(0, 0, '0, 0, 0);
    checks++; if (valid0_o !== 1'b1 || valid1_o !== 1'b1 || cnt0_o !== mcnt0 || cnt1_o !== mcnt1) begin errors++; $display("FAIL arst_pre: got v=%b%b cnt=%h/%h expected v=11 cnt=%h/%h", valid0_o, valid1_o, cnt0_o, cnt1_o, mcnt0, mcnt1); end
    #1;
    rst_n = 0;
    #1;
    checks++; if (valid0_o !== 1'b0 || valid1_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b%b expected 00", valid0_o, valid1_o); end
    checks++; if (cnt0_o !== '0 || cnt1_o !== '0 || data0_o !== '0 || data1_o !== '0) begin errors++; $display("FAIL arst_state: got cnt=%h/%h d=%h/%h expected zeros", cnt0_o, cnt1_o, data0_o, data1_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b expected 1", ready_o); end
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_alternate();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(i < 8, i[0], DW'(i), 1, 1);
      if (i > 0) begin
        if (((i - 1) % 2) == 0) begin
          checks++; if (valid0_o !== 1'b1 || data0_o !== DW'(i - 1) || valid1_o !== 1'b0) begin errors++; $display("FAIL alt_even[%0d]: got v=%b%b d0=%h expected v0=1 v1=0 d0=%h", i, valid0_o, valid1_o, data0_o, i - 1); end
        end else begin
          checks++; if (valid1_o !== 1'b1 || data1_o !== DW'(i - 1) || valid0_o !== 1'b0) begin errors++; $display("FAIL alt_odd[%0d]: got v=%b%b d1=%h expected v0=0 v1=1 d1=%h", i, valid0_o, valid1_o, data1_o, i - 1); end
        end
      end
      tick();
    end
    drive(0, 0, '0, 1, 1);
    checks++; if (cnt0_o !== 16'd4 || cnt1_o !== 16'd4) begin errors++; $display("FAIL alt_cnt: got %0d/%0d expected 4/4", cnt0_o, cnt1_o); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 65536; i++) begin
      drive(1, 0, DW'(i), 1, 0);
      tick();
    end
    drive(0, 0, '0, 1, 0);
    checks++; if (cnt0_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h expected ffff", cnt0_o); end
    tick();
    drive(0, 0, '0, 0, 0);
    checks++; if (cnt0_o !== 16'h0000 || cnt0_o !== mcnt0) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", cnt0_o); end
  endtask

  initial begin
    rst_n = 0; valid_i = 0; select_i = 0; data_i = '0; ready0_i = 0; ready1_i = 0;
    test_reset();
    test_stream();
    test_stall();
    test_push_pop();
    test_random();
    test_async_reset();
    test_alternate();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
